axi4_lite_write_arbiter: RTL and testbench

Shares one AXI4-Lite master write port (AW, W and B channels) between NUM_REQ local requesters. It grants one requester at a time and captures its address, data, strobe and protection. It sequences the AW and W handshakes and the B response, then returns the response to the granted requester. It sits between on-chip write sources and the master write interface signals in the AXI4-Lite master agent.

---
 rtl/axi4_lite_globals_pkg.sv | 18 +
 rtl/axi4_lite_rr_arbiter.sv | 39 +++
 rtl/axi4_lite_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi4_lite_write_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_globals_pkg.sv
// rtl/axi4_lite_globals_pkg.sv - shared AXI4-Lite widths, write FSM states and response codes
package Axi4LiteGlobalsPkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int STRB_WIDTH    = DATA_WIDTH / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// rtl/axi4_lite_rr_arbiter.sv - one-hot grant from a request vector, rotating from a pointer
// Build option: AXI4LITE_WR_FIXED_PRIO_EN makes the lowest requesting index always win.
module axi4_lite_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

`ifdef AXI4LITE_WR_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  // Walk the requesters in priority order and take the first one found.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef AXI4LITE_WR_FIXED_PRIO_EN
      idx = PTR_W'(k);
`else
      idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
`endif
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// rtl/axi4_lite_write_arbiter.sv - shares one AXI4-Lite AW/W/B master port among NUM_REQ requesters
// Build option: AXI4LITE_WR_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module axi4_lite_write_arbiter
  import Axi4LiteGlobalsPkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  input  logic [NUM_REQ*3-1:0]             req_prot,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [1:0]                       rsp_resp,
  output logic [ADDRESS_WIDTH-1:0]         awaddr,
  output logic [2:0]                       awprot,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic [STRB_WIDTH-1:0]            wstrb,
  output logic                             wvalid,
  input  logic                             wready,
  input  logic [1:0]                       bresp,
  input  logic                             bvalid,
  output logic                             bready
);

  localparam int PTR_W = $clog2(NUM_REQ);

  wr_state_e                state_q;
  logic [PTR_W-1:0]         ptr_q;
  logic [PTR_W-1:0]         ptr_d;
  logic [PTR_W-1:0]         owner_q;
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [2:0]               awprot_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_WIDTH-1:0]    wstrb_q;
  logic                     awvalid_q;
  logic                     wvalid_q;
  logic                     bready_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [1:0]               rsp_resp_q;

  logic                     arb_en;
  logic [NUM_REQ-1:0]       gnt;
  logic [PTR_W-1:0]         gnt_idx;
  logic                     aw_done;
  logic                     w_done;

  logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]    data_arr [NUM_REQ];
  logic [STRB_WIDTH-1:0]    strb_arr [NUM_REQ];
  logic [2:0]               prot_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[i] = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
    assign prot_arr[i] = req_prot[i*3 +: 3];
  end

  // Gating with aresetn keeps a request from being accepted while reset is held.
  assign arb_en = aresetn && (state_q == IDLE);

  axi4_lite_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // A channel counts as done once its valid has dropped or it handshakes this cycle.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      awaddr_q    <= '0;
      awprot_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q   <= gnt_idx;
            ptr_q     <= ptr_d;
            awaddr_q  <= addr_arr[gnt_idx];
            awprot_q  <= prot_arr[gnt_idx];
            wdata_q   <= data_arr[gnt_idx];
            wstrb_q   <= strb_arr[gnt_idx];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= bresp;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign awaddr    = awaddr_q;
  assign awprot    = awprot_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// tb/tb_axi4_lite_write_arbiter.sv - self-checking bench for axi4_lite_write_arbiter
// Honours AXI4LITE_WR_FIXED_PRIO_EN when choosing the expected winner.
module tb_axi4_lite_write_arbiter;
  import Axi4LiteGlobalsPkg::*;

  localparam int N  = 4;
  localparam int SW = STRB_WIDTH;

  logic                       aclk = 1'b0;
  logic                       aresetn;
  logic [N-1:0]               req_valid;
  logic [N-1:0]               req_ready;
  logic [N*ADDRESS_WIDTH-1:0] req_addr;
  logic [N*DATA_WIDTH-1:0]    req_data;
  logic [N*SW-1:0]            req_strb;
  logic [N*3-1:0]             req_prot;
  logic [N-1:0]               rsp_valid;
  logic [1:0]                 rsp_resp;
  logic [ADDRESS_WIDTH-1:0]   awaddr;
  logic [2:0]                 awprot;
  logic                       awvalid;
  logic                       awready;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [SW-1:0]              wstrb;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;

  always #5 aclk = ~aclk;

  axi4_lite_write_arbiter #(.NUM_REQ(N)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_resp  (rsp_resp),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDRESS_WIDTH-1:0] r_addr [N];
  logic [DATA_WIDTH-1:0]    r_data [N];
  logic [SW-1:0]            r_strb [N];
  logic [2:0]               r_prot [N];

  // Reference model: one write in flight, tracked as outstanding AW / W / B obligations.
  int                       m_ptr, m_owner, m_done_owner;
  bit                       m_busy, m_aw, m_w, m_b, m_rsp;
  logic [1:0]               m_resp;
  logic [ADDRESS_WIDTH-1:0] m_addr;
  logic [2:0]               m_prot;
  logic [DATA_WIDTH-1:0]    m_data;
  logic [SW-1:0]            m_strb;
  int                       pop_idx;

  int                       cnt_send, cnt_b, aw_delay, w_delay, b_delay;
  logic [1:0]               b_code;
  bit                       auto_gen, rand_slave, noise;
  int                       d_aw, d_w, d_b;
  logic [1:0]               d_resp;
  int                       grants[$];
  int                       obs_gnt, obs_rsp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_winner(input logic [N-1:0] v, input int ptr);
    int i;
    for (int k = 0; k < N; k++) begin
`ifdef AXI4LITE_WR_FIXED_PRIO_EN
      i = k;
`else
      i = (ptr + k) % N;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_done_owner = 0;
    m_busy = 0; m_aw = 0; m_w = 0; m_b = 0; m_rsp = 0;
    m_resp = '0; cnt_send = 0; cnt_b = 0; pop_idx = -1;
    obs_gnt = obs_rsp;
  endtask

  task automatic pack_reqs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = r_addr[i];
      req_data[i*DATA_WIDTH +: DATA_WIDTH]       = r_data[i];
      req_strb[i*SW +: SW]                       = r_strb[i];
      req_prot[i*3 +: 3]                         = r_prot[i];
    end
  endtask

  task automatic rand_payload(input int i);
    r_addr[i] = ADDRESS_WIDTH'($urandom);
    r_data[i] = DATA_WIDTH'($urandom);
    r_strb[i] = SW'($urandom);
    r_prot[i] = 3'($urandom);
  endtask

  task automatic gen_reqs();
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
        rand_payload(i);
        req_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic drive_slave();
    if (m_aw) awready = (cnt_send >= aw_delay);
    else      awready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (m_w)  wready = (cnt_send >= w_delay);
    else      wready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (m_b) begin
      bvalid = (cnt_b >= b_delay);
      bresp  = b_code;
    end else begin
      bvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bresp  = 2'($urandom);
    end
  endtask

  task automatic check_outputs();
    int w;
    w = m_busy ? -1 : exp_winner(req_valid, m_ptr);
    check_eq("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
    for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    if (req_ready != '0) obs_gnt++;
    if (rsp_valid != '0) obs_rsp++;
    check_eq("awvalid", 64'(awvalid), 64'(m_aw));
    check_eq("wvalid", 64'(wvalid), 64'(m_w));
    check_eq("bready", 64'(bready), 64'(m_b));
    if (m_aw) begin
      check_eq("awaddr", 64'(awaddr), 64'(m_addr));
      check_eq("awprot", 64'(awprot), 64'(m_prot));
    end
    if (m_w) begin
      check_eq("wdata", 64'(wdata), 64'(m_data));
      check_eq("wstrb", 64'(wstrb), 64'(m_strb));
    end
    check_eq("rsp_valid", 64'(rsp_valid), m_rsp ? (64'd1 << m_done_owner) : 64'd0);
    if (m_rsp) check_eq("rsp_resp", 64'(rsp_resp), 64'(m_resp));
  endtask

  task automatic update_model();
    int w;
    w = m_busy ? -1 : exp_winner(req_valid, m_ptr);
    m_rsp   = 1'b0;
    pop_idx = -1;
    if (m_b) begin
      if (bvalid) begin
        m_rsp = 1'b1; m_resp = bresp; m_done_owner = m_owner;
        m_b = 1'b0; m_busy = 1'b0;
      end else begin
        cnt_b++;
      end
    end else if (m_aw || m_w) begin
      if (awready) m_aw = 1'b0;
      if (wready)  m_w  = 1'b0;
      if (!m_aw && !m_w) begin
        m_b = 1'b1; cnt_b = 0;
      end
      cnt_send++;
    end
    if (w >= 0) begin
      m_owner = w;
      m_addr = r_addr[w]; m_data = r_data[w]; m_strb = r_strb[w]; m_prot = r_prot[w];
      m_busy = 1'b1; m_aw = 1'b1; m_w = 1'b1; cnt_send = 0;
      m_ptr = (w + 1) % N;
      pop_idx = w;
      if (rand_slave) begin
        aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
        b_delay = $urandom_range(0, 4); b_code = 2'($urandom);
      end else begin
        aw_delay = d_aw; w_delay = d_w; b_delay = d_b; b_code = d_resp;
      end
    end
  endtask

  task automatic run_cycle();
    drive_slave();
    pack_reqs();
    @(negedge aclk);
    check_outputs();
    @(posedge aclk);
    update_model();
    #1;
    if (pop_idx >= 0) req_valid[pop_idx] = 1'b0;
    if (auto_gen) gen_reqs();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int c;
    c = 0;
    while ((m_busy || m_rsp || req_valid != '0) && c < max_cycles) begin
      run_cycle();
      c++;
    end
    check_eq({tag, "_bound"}, 64'(c >= max_cycles), 64'd0);
    check_eq({tag, "_idle"}, {61'd0, awvalid, wvalid, bready}, 64'd0);
  endtask

  task automatic apply_reset();
    aresetn   = 1'b0;
    req_valid = '1;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_resp", 64'(rsp_resp), 64'd0);
    check_eq("rst_valids", {61'd0, awvalid, wvalid, bready}, 64'd0);
    check_eq("rst_awaddr", 64'(awaddr), 64'd0);
    check_eq("rst_awprot", 64'(awprot), 64'd0);
    check_eq("rst_wdata", 64'(wdata), 64'd0);
    check_eq("rst_wstrb", 64'(wstrb), 64'd0);
    req_valid = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    int exp_order [5];
    aresetn = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_data[i] = '0; r_strb[i] = '0; r_prot[i] = '0;
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    auto_gen = 0; rand_slave = 0; noise = 0;
    d_aw = 0; d_w = 0; d_b = 0; d_resp = OKAY;
    aw_delay = 0; w_delay = 0; b_delay = 0; b_code = OKAY;
    obs_gnt = 0; obs_rsp = 0;
    pack_reqs();
    #1;
    apply_reset();

    // All requesters held valid from reset: rotation order.
    for (int i = 0; i < N; i++) rand_payload(i);
    grants.delete();
    for (int c = 0; c < 40 && grants.size() < 5; c++) begin
      req_valid = '1;
      run_cycle();
    end
    req_valid = '0;
    drain("held_drain", 20);
`ifdef AXI4LITE_WR_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check_eq("held_grant_count", 64'(grants.size() >= 5), 64'd1);
    if (grants.size() >= 5)
      for (int k = 0; k < 5; k++) check_eq("held_grant_order", 64'(grants[k]), 64'(exp_order[k]));

    // Single request, zero-wait slave.
    r_addr[1] = 32'h0000_0010; r_data[1] = 32'hDEAD_BEEF; r_strb[1] = 4'hF; r_prot[1] = 3'd0;
    req_valid = 4'b0010;
    repeat (5) run_cycle();
    drain("single_drain", 10);

    // awready held off three cycles, wready immediate.
    d_aw = 3;
    rand_payload(2);
    req_valid = 4'b0100;
    drain("aw_delay", 30);
    d_aw = 0;

    // bvalid held off five cycles with SLVERR; a second request waits meanwhile.
    d_b = 5; d_resp = SLVERR;
    rand_payload(3);
    req_valid = 4'b1000;
    run_cycle();
    rand_payload(0);
    req_valid[0] = 1'b1;
    drain("b_delay", 40);
    d_b = 0; d_resp = OKAY;

    // Reset in SEND abandons the write and returns the pointer to 0.
    d_aw = 5;
    rand_payload(1);
    req_valid = 4'b0010;
    run_cycle();
    run_cycle();
    apply_reset();
    d_aw = 0;
    rand_payload(1); rand_payload(3);
    req_valid = 4'b1010;
    grants.delete();
    run_cycle();
    check_eq("post_rst_grant_seen", 64'(grants.size()), 64'd1);
    if (grants.size() >= 1) check_eq("post_rst_grant", 64'(grants[0]), 64'd1);
    drain("post_rst_drain", 40);

    // Randomised traffic with a randomised slave and ignored-channel noise.
    auto_gen = 1; rand_slave = 1; noise = 1;
    repeat (1500) run_cycle();
    auto_gen = 0; noise = 0;
    drain("rand_drain", 300);
    check_eq("grants_vs_rsps", 64'(obs_gnt), 64'(obs_rsp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
